// File: rtl/data_mem_lsu_pkg.sv
// Shared types for the RV32 data memory / load-store unit.
// Latency: n/a (types, constants and a pure legality function only).
// Backpressure: n/a.
package dmem_pkg;

  // RV32 funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {INIT, RUN} dmem_state_e;

  // One response pipeline stage; word holds the raw array word for loads
  typedef struct packed {
    logic        valid;
    logic        err;
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] word;
  } dmem_stage_t;

  // Alignment and encoding legality of one access.
  // Unsigned variants only exist for loads; halves need an even address,
  // words need a 4-byte aligned address.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a core LSU port and the data memory.
// Latency: n/a (wiring only).
// Backpressure: request side valid/ready; response side is a one-cycle strobe with no ready.
// Ports: req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata;
//        rsp_valid strobe, rsp_rdata, rsp_err.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu_lane_align.sv
// Byte-lane steering for RV32 loads and stores (byte enables, store replication, load extend).
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: st_funct3/st_off/st_wdata -> st_be/st_wdata_rep; ld_funct3/ld_off/ld_word -> ld_data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    st_be        = 4'b0000;
    st_wdata_rep = 32'h0;
    case (st_funct3)
      F3_B: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_be        = 4'b0011 << st_off;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      F3_W: begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
      end
      default: begin
        st_be        = 4'b0000;
        st_wdata_rep = 32'h0;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0 before extending
  assign ld_shift = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with load/store unit, optional zero-fill after reset.
// Latency: every response (load, store or error) exactly READ_LATENCY cycles after acceptance.
// Backpressure: req_ready low only while zero-filling; responses cannot be stalled.
// Ports: clk, rst_n (async active-low), bus (slave side of data_mem_lsu_if).
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 9,
  parameter int READ_LATENCY   = 1,   // legal range 1..4
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_lsu_if.slave  bus
);

  localparam int ADDR_W = DEPTH_LOG2 + 2;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_WORD = '1;

  logic [31:0]           mem [DEPTH];
  dmem_state_e           state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  ready_q;

  logic                  accept;
  logic                  legal;
  logic                  st_en;
  logic                  clr_en;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [1:0]            req_off;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata_rep;
  logic [31:0]           ld_data;

  dmem_stage_t           s0;
  dmem_stage_t           pipe [READ_LATENCY];
  dmem_stage_t           last;

  assign req_idx = bus.req_addr[ADDR_W-1:2];
  assign req_off = bus.req_addr[1:0];
  assign accept  = bus.req_valid && ready_q;
  assign legal   = access_legal(bus.req_we, bus.req_funct3, req_off);
  assign st_en   = accept && legal && bus.req_we;
  // Gate on rst_n so clock edges during reset never touch the array
  assign clr_en  = (state == INIT) && rst_n;

  // Zero-fill sequencer; ready only rises once the last word is cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) state <= INIT;
      else                     state <= RUN;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_WORD) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     ready_q <= 1'b1;
        default: state   <= RUN;
      endcase
    end
  end

  // Array has no reset; only enabled byte lanes are written
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_cnt] <= 32'h0;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[req_idx][8*b +: 8] <= st_wdata_rep[8*b +: 8];
      end
    end
  end

  // Stage-1 contents; reading the pre-write word is fine since loads and
  // stores never share an accepting edge
  always_comb begin
    s0        = '0;
    s0.valid  = accept;
    s0.err    = accept && !legal;
    s0.we     = bus.req_we;
    s0.funct3 = bus.req_funct3;
    s0.off    = req_off;
    s0.word   = (accept && legal && !bus.req_we) ? mem[req_idx] : 32'h0;
  end

  // Fixed-depth delay line; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[READ_LATENCY-1];

  dmem_lane_align u_align (
    .st_funct3    (bus.req_funct3),
    .st_off       (req_off),
    .st_wdata     (bus.req_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_funct3    (last.funct3),
    .ld_off       (last.off),
    .ld_word      (last.word),
    .ld_data      (ld_data)
  );

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = last.valid;
  assign bus.rsp_err   = last.valid && last.err;
  assign bus.rsp_rdata = (last.valid && !last.err && !last.we) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu (DEPTH_LOG2=4, READ_LATENCY=3, CLEAR_ON_RESET=1).
// Latency: responses expected exactly 3 cycles after acceptance.
// Backpressure: waits for zero-fill before issuing requests.
module tb_data_mem_lsu;

  localparam int DL2 = 4;
  localparam int LAT = 3;
  localparam int AW  = DL2 + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_lsu_if #(.ADDR_W(AW)) bus ();

  data_mem_lsu #(
    .DEPTH_LOG2     (DL2),
    .READ_LATENCY   (LAT),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One request, then wait (bounded) for its response; lat counts falling
  // edges after the accepting edge, so lat==LAT means on-time
  task automatic xact(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  // Release reset and count rising edges until req_ready is seen high
  task automatic release_and_count(output int n, output int stale);
    n = 0;
    stale = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) stale++;
    end while (bus.req_ready !== 1'b1 && n < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    checks++;
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b want 0", bus.rsp_err); end
  endtask

  task automatic test_init_clear();
    int n, stale, lat;
    logic [31:0] rd;
    logic er;
    release_and_count(n, stale);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL init_ready_delay got %0d edges want 16", n); end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL init_rsp_valid got %0d strobes want 0", stale); end
    for (int w = 0; w < 16; w++) begin
      xact(1'b0, 3'd2, AW'(w * 4), 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== LAT) begin
        errors++;
        $display("FAIL init_lw word %0d got rdata=%h err=%0b lat=%0d want 00000000/0/%0d", w, rd, er, lat, LAT);
      end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd1};
    logic [5:0]  ad [7] = '{6'h13, 6'h13, 6'h12, 6'h10, 6'h10, 6'h11, 6'h10};
    logic [31:0] ex [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                            32'h80FF7F01, 32'h0000007F, 32'h00007F01};
    logic [31:0] rd;
    logic er;
    int lat;
    xact(1'b1, 3'd2, 6'h10, 32'h80FF7F01, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== LAT) begin
      errors++;
      $display("FAIL sw_rsp got rdata=%h err=%0b lat=%0d want 00000000/0/%0d", rd, er, lat, LAT);
    end
    for (int i = 0; i < 7; i++) begin
      xact(1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
      checks++;
      if (rd !== ex[i] || er !== 1'b0 || lat !== LAT) begin
        errors++;
        $display("FAIL load_ext f3=%0d addr=%h got rdata=%h err=%0b lat=%0d want %h/0/%0d",
                 f3[i], ad[i], rd, er, lat, ex[i], LAT);
      end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd;
    logic er;
    int lat;
    xact(1'b1, 3'd2, 6'h20, 32'h11223344, rd, er, lat);
    xact(1'b1, 3'd0, 6'h21, 32'h123456AA, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb_rsp got rdata=%h err=%0b want 0/0", rd, er); end
    xact(1'b0, 3'd2, 6'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge got %h want 1122aa44", rd); end
    xact(1'b1, 3'd1, 6'h22, 32'hCAFEBEEF, rd, er, lat);
    xact(1'b0, 3'd2, 6'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hBEEFAA44) begin errors++; $display("FAIL sh_merge got %h want beefaa44", rd); end
  endtask

  task automatic test_illegal();
    logic        we [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [6] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
    logic [5:0]  ad [6] = '{6'h22, 6'h01, 6'h05, 6'h20, 6'h20, 6'h20};
    logic [31:0] rd;
    logic er;
    int lat;
    xact(1'b1, 3'd2, 6'h04, 32'h01020304, rd, er, lat);
    for (int i = 0; i < 6; i++) begin
      xact(we[i], f3[i], ad[i], 32'hDEADBEEF, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1 || lat !== LAT) begin
        errors++;
        $display("FAIL illegal we=%0b f3=%0d addr=%h got rdata=%h err=%0b lat=%0d want 00000000/1/%0d",
                 we[i], f3[i], ad[i], rd, er, lat, LAT);
      end
    end
    xact(1'b0, 3'd2, 6'h04, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h01020304) begin errors++; $display("FAIL illegal_nowrite_w1 got %h want 01020304", rd); end
    xact(1'b0, 3'd2, 6'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hBEEFAA44) begin errors++; $display("FAIL illegal_nowrite_w8 got %h want beefaa44", rd); end
  endtask

  task automatic test_back_to_back();
    logic        we [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0]  ad [8] = '{6'h30, 6'h34, 6'h38, 6'h3C, 6'h3C, 6'h38, 6'h34, 6'h30};
    logic [31:0] wd [8] = '{32'hA5A50001, 32'h12345678, 32'hDEADBEEF, 32'h0BADF00D,
                            32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ex [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                            32'h0BADF00D, 32'hDEADBEEF, 32'h12345678, 32'hA5A50001};
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bus.req_valid  = 1'b1;
          bus.req_we     = we[i];
          bus.req_funct3 = 3'd2;
          bus.req_addr   = ad[i];
          bus.req_wdata  = wd[i];
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
      end
      begin
        int seen;
        logic exp_v;
        seen = 0;
        @(negedge clk);
        for (int k = 1; k <= 14; k++) begin
          @(negedge clk);
          exp_v = (k >= LAT) && (k <= LAT + 7);
          checks++;
          if (bus.rsp_valid !== exp_v) begin
            errors++;
            $display("FAIL b2b_valid cycle A+%0d got %0b want %0b", k, bus.rsp_valid, exp_v);
          end
          if (bus.rsp_valid === 1'b1 && seen < 8) begin
            checks++;
            if (bus.rsp_rdata !== ex[seen] || bus.rsp_err !== 1'b0) begin
              errors++;
              $display("FAIL b2b_data rsp %0d got rdata=%h err=%0b want %h/0",
                       seen, bus.rsp_rdata, bus.rsp_err, ex[seen]);
            end
            seen++;
          end
        end
      end
    join
  endtask

  task automatic test_reset_in_flight();
    int n, stale, lat;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 6'h30;
    @(negedge clk);
    bus.req_addr = 6'h34;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL flight_reset_outputs got valid=%0b ready=%0b rdata=%h err=%0b want 0/0/0/0",
               bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flight_in_reset cycle %0d got valid=1 want 0", k); end
    end
    // Abort the zero-fill part way; the next release must take the full 16 again
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_init_ready got 1 want 0"); end
    rst_n = 1'b0;
    @(negedge clk);
    release_and_count(n, stale);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL init_restart got %0d edges want 16", n); end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL stale_rsp got %0d strobes want 0", stale); end
    xact(1'b0, 3'd2, 6'h30, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== LAT) begin
      errors++;
      $display("FAIL refill_lw got rdata=%h err=%0b lat=%0d want 00000000/0/%0d", rd, er, lat, LAT);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_init_clear();
    test_load_extend();
    test_partial_store();
    test_illegal();
    test_back_to_back();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
